// File: rtl/bypass_pkg.sv
// Shared types for the register-file bypass: operand/address aliases and forwarding source record.
package bypass_pkg;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  typedef logic [REG_WIDTH-1:0]  reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic      en;
    logic      ready;
    reg_addr_t addr;
    data_t     data;
  } fwd_src_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/bypass_port_mux.sv
// One read port: youngest-first forwarding mux over the pipeline stages plus hazard detect.
// Purely combinational; a hazard is a pending (not ready) forwarder or a busy scoreboard entry.
module bypass_port_mux
  import bypass_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 3
) (
  input  logic                                 rd_en_i,
  input  logic [REG_WIDTH-1:0]                 rd_addr_i,
  input  logic [DATA_WIDTH-1:0]                rf_data_i,
  input  logic                                 busy_i,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_en_i,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_ready_i,
  input  logic [NUM_FWD_STAGES*REG_WIDTH-1:0]  fwd_addr_i,
  input  logic [NUM_FWD_STAGES*DATA_WIDTH-1:0] fwd_data_i,
  output logic [DATA_WIDTH-1:0]                rd_data_o,
  output logic                                 hazard_o
);

  fwd_src_t src;
  logic     hit;
  logic     hit_ready;

  always_comb begin
    rd_data_o = rf_data_i;
    hazard_o  = 1'b0;
    hit       = 1'b0;
    hit_ready = 1'b1;
    src       = '0;
    // Walk oldest to youngest so the youngest matching stage overrides.
    for (int s = NUM_FWD_STAGES - 1; s >= 0; s--) begin
      src.en    = fwd_en_i[s];
      src.ready = fwd_ready_i[s];
      src.addr  = fwd_addr_i[s*REG_WIDTH +: REG_WIDTH];
      src.data  = fwd_data_i[s*DATA_WIDTH +: DATA_WIDTH];
      if (src.en && (src.addr == rd_addr_i)) begin
        hit       = 1'b1;
        hit_ready = src.ready;
        rd_data_o = src.data;
      end
    end
    if (!rd_en_i || (rd_addr_i == ZERO_REG)) begin
      rd_data_o = '0;
    end else begin
      hazard_o = (hit && !hit_ready) || busy_i;
    end
  end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port operand bypass with a countdown scoreboard for long-latency writers.
// Operand path is combinational; scoreboard and stall counter update on the next edge.
module regfile_bypass_sb
  import bypass_pkg::*;
#(
  parameter int NUM_RD_PORTS   = 2,
  parameter int NUM_FWD_STAGES = 3,
  parameter int NUM_REGS       = 32,
  parameter int LAT_WIDTH      = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_RD_PORTS-1:0]              rd_en,
  input  logic [NUM_RD_PORTS*REG_WIDTH-1:0]    rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]              rf_en,
  output logic [NUM_RD_PORTS*REG_WIDTH-1:0]    rf_addr,
  input  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rf_data,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_en,
  input  logic [NUM_FWD_STAGES-1:0]            fwd_ready,
  input  logic [NUM_FWD_STAGES*REG_WIDTH-1:0]  fwd_addr,
  input  logic [NUM_FWD_STAGES*DATA_WIDTH-1:0] fwd_data,
  input  logic                                 issue_valid,
  input  logic                                 issue_wr_en,
  input  logic [REG_WIDTH-1:0]                 issue_wr_addr,
  input  logic [LAT_WIDTH-1:0]                 issue_lat,
  input  logic                                 flush,
  output logic                                 stall,
  output logic [31:0]                          stall_cnt
);

  logic [NUM_REGS-1:0]                busy_q, busy_d;
  logic [NUM_REGS-1:0][LAT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]                        stall_cnt_q, stall_cnt_d;
  logic [NUM_RD_PORTS-1:0]            hazard;
  logic                               issue_fire;

  assign rf_en   = rd_en;
  assign rf_addr = rd_addr;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    bypass_port_mux #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES)
    ) u_mux (
      .rd_en_i    (rd_en[p]),
      .rd_addr_i  (rd_addr[p*REG_WIDTH +: REG_WIDTH]),
      .rf_data_i  (rf_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .busy_i     (busy_q[rd_addr[p*REG_WIDTH +: REG_WIDTH]]),
      .fwd_en_i   (fwd_en),
      .fwd_ready_i(fwd_ready),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .rd_data_o  (rd_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .hazard_o   (hazard[p])
    );
  end

  assign stall      = |hazard;
  assign issue_fire = issue_valid && !stall && !flush;
  assign stall_cnt  = stall_cnt_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (busy_q[r]) begin
        if (cnt_q[r] == LAT_WIDTH'(1)) begin
          busy_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LAT_WIDTH'(1);
        end
      end
    end
    // A new issue overrides an entry expiring in the same cycle.
    if (issue_fire && issue_wr_en && (issue_wr_addr != ZERO_REG) && (issue_lat != '0)) begin
      busy_d[issue_wr_addr] = 1'b1;
      cnt_d[issue_wr_addr]  = issue_lat;
    end
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: inputs driven at negedge, outputs checked 1ns later.
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rf_en;
  logic [9:0]  rf_addr;
  logic [63:0] rf_data;
  logic [2:0]  fwd_en, fwd_ready;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;
  logic        issue_valid, issue_wr_en;
  logic [4:0]  issue_wr_addr;
  logic [2:0]  issue_lat;
  logic        flush;
  logic        stall;
  logic [31:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rf_en(rf_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .fwd_en(fwd_en), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
    .issue_wr_addr(issue_wr_addr), .issue_lat(issue_lat),
    .flush(flush), .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; rf_data = '0;
    fwd_en = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
    issue_valid = 1'b0; issue_wr_en = 1'b0; issue_wr_addr = '0; issue_lat = '0;
    flush = 1'b0;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [31:0] rf);
    rd_en[p] = 1'b1;
    rd_addr[p*5 +: 5] = a;
    rf_data[p*32 +: 32] = rf;
  endtask

  task automatic fwd(input int s, input logic rdy, input logic [4:0] a, input logic [31:0] d);
    fwd_en[s] = 1'b1;
    fwd_ready[s] = rdy;
    fwd_addr[s*5 +: 5] = a;
    fwd_data[s*32 +: 32] = d;
  endtask

  task automatic issue(input logic [4:0] a, input logic [2:0] lat);
    issue_valid = 1'b1; issue_wr_en = 1'b1; issue_wr_addr = a; issue_lat = lat;
  endtask

  // Advance to the next negedge with all inputs cleared.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    cyc(); #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rd_data0", rd_data[31:0], 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // Plain register-file reads
    cyc(); rd(0, 5'd3, 32'h22); rd(1, 5'd5, 32'h11); #1;
    chk("rf_p0", rd_data[31:0], 32'h22);
    chk("rf_p1", rd_data[63:32], 32'h11);
    chk("rf_stall", {31'd0, stall}, 32'd0);
    chk("rf_addr_pass", {22'd0, rf_addr}, {22'd0, 5'd5, 5'd3});
    chk("rf_en_pass", {30'd0, rf_en}, 32'd3);

    // Youngest stage wins; r0 always reads zero
    cyc(); fwd(0, 1'b1, 5'd5, 32'hAAAA); fwd(2, 1'b1, 5'd5, 32'hBBBB); fwd(1, 1'b1, 5'd0, 32'hCCCC);
    rd(1, 5'd5, 32'h55); rd(0, 5'd0, 32'h77); #1;
    chk("fwd_young", rd_data[63:32], 32'hAAAA);
    chk("fwd_r0", rd_data[31:0], 32'd0);
    chk("fwd_stall", {31'd0, stall}, 32'd0);
    cyc(); fwd(2, 1'b1, 5'd5, 32'hBBBB); rd(1, 5'd5, 32'h55); #1;
    chk("fwd_old", rd_data[63:32], 32'hBBBB);
    cyc(); fwd(0, 1'b1, 5'd5, 32'hAAAA); rd_addr[4:0] = 5'd5; rf_data[31:0] = 32'h99; #1;
    chk("rd_en_off", rd_data[31:0], 32'd0);

    // Load-use: lat=2 stalls exactly two cycles
    cyc(); issue(5'd7, 3'd2);
    cyc(); rd(0, 5'd7, 32'h0); #1;
    chk("lu_stall1", {31'd0, stall}, 32'd1);
    cyc(); rd(0, 5'd7, 32'h0); #1;
    chk("lu_stall2", {31'd0, stall}, 32'd1);
    cyc(); rd(0, 5'd7, 32'h0); fwd(1, 1'b1, 5'd7, 32'h1234); #1;
    chk("lu_data", rd_data[31:0], 32'h1234);
    chk("lu_stall3", {31'd0, stall}, 32'd0);
    chk("lu_cnt", stall_cnt, 32'd2);

    // Pending forwarder stalls and blocks issue
    cyc(); fwd(0, 1'b0, 5'd9, 32'hDEAD); rd(1, 5'd9, 32'h0); issue(5'd10, 3'd3); #1;
    chk("pend_stall", {31'd0, stall}, 32'd1);
    cyc(); rd(0, 5'd10, 32'h0); #1;
    chk("pend_no_entry", {31'd0, stall}, 32'd0);
    chk("pend_cnt", stall_cnt, 32'd3);

    // Flush clears a live entry
    cyc(); issue(5'd4, 3'd5);
    cyc(); rd(0, 5'd4, 32'h0); #1;
    chk("fl_busy", {31'd0, stall}, 32'd1);
    cyc(); flush = 1'b1;
    cyc(); rd(0, 5'd4, 32'h0); #1;
    chk("fl_cleared", {31'd0, stall}, 32'd0);
    // Flush beats a simultaneous issue
    cyc(); issue(5'd6, 3'd3); flush = 1'b1;
    cyc(); rd(1, 5'd6, 32'h0); #1;
    chk("fl_vs_issue", {31'd0, stall}, 32'd0);
    chk("fl_keeps_cnt", stall_cnt, 32'd4);

    // Issues to r0 or with lat=0 leave the scoreboard alone
    cyc(); issue(5'd8, 3'd0);
    cyc(); rd(0, 5'd8, 32'h0); #1;
    chk("lat0", {31'd0, stall}, 32'd0);

    // Reload on the expiring cycle extends the stall
    cyc(); issue(5'd11, 3'd1);
    cyc(); issue(5'd11, 3'd2);
    cyc(); rd(0, 5'd11, 32'h0); #1;
    chk("reload1", {31'd0, stall}, 32'd1);
    cyc(); rd(0, 5'd11, 32'h0); #1;
    chk("reload2", {31'd0, stall}, 32'd1);
    cyc(); rd(0, 5'd11, 32'h0); #1;
    chk("reload_done", {31'd0, stall}, 32'd0);
    chk("reload_cnt", stall_cnt, 32'd6);

    // Saturation: preload near the top, then four stall cycles
    cyc(); issue(5'd12, 3'd4);
    cyc(); rd(0, 5'd12, 32'h0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    repeat (3) begin
      cyc(); rd(0, 5'd12, 32'h0);
    end
    cyc(); rd(0, 5'd12, 32'h0); #1;
    chk("sat_done", {31'd0, stall}, 32'd0);
    chk("sat_cnt", stall_cnt, 32'hFFFF_FFFF);

    // Reset mid-countdown clears scoreboard and counter
    cyc(); issue(5'd13, 3'd5);
    cyc(); rd(0, 5'd13, 32'h0); #1;
    chk("mid_busy", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_cnt", stall_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised successor to the single-port register-file bypass.
- Serves NUM_RD_PORTS read ports in one cycle and forwards from NUM_FWD_STAGES pipeline stages with youngest-first priority.
- Adds a per-register scoreboard of countdown timers for long-latency writers (load, div, csr), so load-use and multi-cycle hazards produce a registered-state stall.
- Sits between decode/issue and the architectural register file.

Parameters:
- NUM_RD_PORTS, 2, number of independent read ports.
- NUM_FWD_STAGES, 3, number of forwarding sources; index 0 is youngest (EX), highest index is oldest (WB).
- NUM_REGS, 32, architectural registers; register 0 is hardwired to zero.
- LAT_WIDTH, 3, width of the writer-latency counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_en  in  NUM_RD_PORTS  per-port read request.
- rd_addr  in  NUM_RD_PORTS*`REG_WIDTH  per-port source register.
- rd_data  out  NUM_RD_PORTS*`DATA_WIDTH  bypassed operand.
- rf_en  out  NUM_RD_PORTS  passthrough of rd_en to the register file.
- rf_addr  out  NUM_RD_PORTS*`REG_WIDTH  passthrough of rd_addr.
- rf_data  in  NUM_RD_PORTS*`DATA_WIDTH  register-file read data.
- fwd_en  in  NUM_FWD_STAGES  stage writes a register.
- fwd_ready  in  NUM_FWD_STAGES  stage data is valid this cycle (0 = load/div still pending).
- fwd_addr  in  NUM_FWD_STAGES*`REG_WIDTH  stage destination register.
- fwd_data  in  NUM_FWD_STAGES*`DATA_WIDTH  stage result.
- issue_valid  in  1  an instruction leaves decode this cycle.
- issue_wr_en  in  1  issuing instruction writes a register.
- issue_wr_addr  in  `REG_WIDTH  issuing instruction's destination.
- issue_lat  in  LAT_WIDTH  cycles until its result is forwardable with fwd_ready=1; 0 means none.
- flush  in  1  pipeline flush.
- stall  out  1  hold decode.
- stall_cnt  out  32  saturating count of stalled cycles.

Behaviour:
- rd_data per port p, combinational, priority order:
  - rd_en[p]=0 gives 0.
  - rd_addr=0 gives 0.
  - Otherwise the lowest stage s with fwd_en[s] and matching fwd_addr[s] supplies fwd_data[s], even if fwd_ready[s]=0; the data is don't-care because stall is raised.
  - Otherwise rf_data[p].
- Port hazard: rd_en[p] and rd_addr!=0 and one of:
  - the first matching stage has fwd_ready=0, or
  - busy[rd_addr]=1.
- stall = OR of port hazards. Combinational from inputs plus registered busy.
- issue_fire = issue_valid & ~stall & ~flush.
- Scoreboard: busy[NUM_REGS] and cnt[NUM_REGS][LAT_WIDTH], all 0 on rst.
  - On issue_fire with issue_wr_en, issue_wr_addr!=0 and issue_lat!=0: busy<=1, cnt<=issue_lat.
  - Else if busy: cnt decrements each cycle; when cnt==1, next cycle busy<=0 and cnt<=0.
  - The final stall cycle for issue_lat=L is the L-th cycle after issue; operands become readable via forwarding on cycle L+1.
- Simultaneous events:
  - New issue to a register whose timer expires that cycle: the new issue wins (reload).
  - Flush with issue in the same cycle: flush wins; all busy and cnt cleared next cycle and no entry is created.
  - Issue to r0, or with issue_lat=0: scoreboard is unchanged.
  - Reset mid-countdown clears everything on the next edge.
- stall_cnt:
  - Increments when stall=1, saturates at 32'hFFFF_FFFF.
  - Cleared only by rst, not by flush.
- Reset values: busy=0, cnt=0, stall_cnt=0. With no rd_en active after reset, stall=0 and rd_data=0.
- No latency on the data path. Scoreboard updates take effect the next cycle.

Decomposition:
- Shared package bypass_pkg:
  - reg_addr_t and data_t aliases of `REG_WIDTH / `DATA_WIDTH.
  - fwd_src_t struct {en, ready, addr, data}.
  - localparam ZERO_REG = 0.
- One sub-module, bypass_port_mux: a single-port priority mux plus hazard detect, instantiated NUM_RD_PORTS times.
- The scoreboard stays in the top module.

Test Plan:
- Reset then rd_en=2'b11, rd_addr={5,3}, rf_data={0x11,0x22}, no fwd -> rd_data={0x11,0x22}, stall=0.
- fwd stage0 and stage2 both write r5 with data 0xAAAA and 0xBBBB, both ready; read r5 -> 0xAAAA, stall=0. Read r0 while a stage writes r0 -> rd_data=0, stall=0.
- Issue load to r7 with issue_lat=2; read r7 on the next two cycles -> stall=1 both cycles, stall_cnt=2. Third cycle with stage1 writing r7=0x1234 ready -> rd_data=0x1234, stall=0.
- Stage0 writes r9 with fwd_ready=0, port1 reads r9 -> stall=1. Same cycle issue_valid=1 -> no scoreboard entry created (issue_fire=0).
- Issue r4 lat=5, flush on cycle 2, then read r4 -> stall=0 on cycle 3. Flush and issue r6 lat=3 in the same cycle -> busy[6]=0 afterwards.
- Force 2^32+3 stall cycles (or preload via a bench force) -> stall_cnt holds 0xFFFF_FFFF. rst pulse mid-countdown -> busy, cnt and stall_cnt=0 next cycle.
